imem_port_arbiter: RTL and testbench



---
 rtl/imem_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 37 +++
 rtl/imem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter: FSM states and
// transaction owners.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } arb_state_e;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } arb_owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. On a tie, the requester that was not granted
// last wins. The pointer advances only when the caller commits a grant.
module rr_arb2
   import imem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_if_i,
   input  logic req_d_i,
   input  logic upd_i,
   output logic gnt_if_o,
   output logic gnt_d_o
);

   arb_owner_e last_q;
   arb_owner_e last_d;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      gnt_if_o = req_if_i & (~req_d_i | (last_q == OWN_D));
      gnt_d_o  = req_d_i & ~gnt_if_o;
      last_d   = last_q;
      if (upd_i && (gnt_if_o || gnt_d_o)) begin
         last_d = gnt_if_o ? OWN_IF : OWN_D;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      if (rst) begin
         last_q <= OWN_D;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one line-wide split-transaction memory port between the fetch-line
// prefetcher and a data requester. Only one transaction is outstanding at a
// time, and fetch lines that go stale across a flush are dropped.
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int LINEWIDTH = 64,
   parameter int ADDRW     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   if_req_i,
   input  logic [ADDRW-1:0]       if_addr_i,
   output logic                   if_ready_o,
   output logic                   if_valid_o,
   output logic [LINEWIDTH-1:0]   if_line_o,
   input  logic                   d_req_i,
   input  logic                   d_we_i,
   input  logic [ADDRW-1:0]       d_addr_i,
   input  logic [LINEWIDTH-1:0]   d_wdata_i,
   input  logic [LINEWIDTH/8-1:0] d_be_i,
   output logic                   d_gnt_o,
   output logic                   d_rvalid_o,
   output logic [LINEWIDTH-1:0]   d_rdata_o,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [ADDRW-1:0]       mem_addr_o,
   output logic [LINEWIDTH-1:0]   mem_wdata_o,
   output logic [LINEWIDTH/8-1:0] mem_be_o,
   input  logic                   mem_gnt_i,
   input  logic                   mem_rvalid_i,
   input  logic [LINEWIDTH-1:0]   mem_rdata_i
);

   localparam int BEW = LINEWIDTH / 8;

   arb_state_e           state_q, state_d;
   arb_owner_e           owner_q;
   logic                 drop_q, drop_d;
   logic [ADDRW-1:0]     addr_q;
   logic                 we_q;
   logic [LINEWIDTH-1:0] wdata_q;
   logic [BEW-1:0]       be_q;

   logic gnt_if, gnt_d;
   logic can_accept, accept, resp_hit;

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst      (rst),
      .req_if_i (if_req_i),
      .req_d_i  (d_req_i),
      .upd_i    (accept),
      .gnt_if_o (gnt_if),
      .gnt_d_o  (gnt_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      unique case (state_q)
         IDLE:    if (accept)       state_d = REQ;
         REQ:     if (mem_gnt_i)    state_d = RESP;
         RESP:    if (mem_rvalid_i) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
      if ((state_q != IDLE) && (owner_q == OWN_IF) && flush_i) begin
         drop_d = 1'b1;
      end
      // The drop marker belongs to one fetch transaction only.
      if (state_d == IDLE) begin
         drop_d = 1'b0;
      end
   end

   always_comb begin
      can_accept  = ~rst & (state_q == IDLE);
      if_ready_o  = can_accept & gnt_if;
      d_gnt_o     = can_accept & gnt_d;
      accept      = if_ready_o | d_gnt_o;
      mem_req_o   = ~rst & (state_q == REQ);
      mem_we_o    = we_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_be_o    = be_q;
      resp_hit    = ~rst & (state_q == RESP) & mem_rvalid_i;
      if_valid_o  = resp_hit & (owner_q == OWN_IF) & ~drop_q & ~flush_i;
      d_rvalid_o  = resp_hit & (owner_q == OWN_D);
      if_line_o   = if_valid_o ? mem_rdata_i : '0;
      d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_IF;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (accept) begin
         if (if_ready_o) begin
            owner_q <= OWN_IF;
            addr_q  <= if_addr_i & ~ADDRW'(7);
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '1;
         end else begin
            owner_q <= OWN_D;
            addr_q  <= d_addr_i;
            we_q    <= d_we_i;
            wdata_q <= d_wdata_i;
            be_q    <= d_be_i;
         end
      end
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter. Expected responses are queued as
// stimulus is issued, and a monitor pops them whenever a valid pulse appears.
module tb_imem_port_arbiter;

   localparam int LW = 64;
   localparam int AW = 32;
   localparam int BW = LW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_ready_o, if_valid_o;
   logic [LW-1:0] if_line_o;
   logic          d_req_i, d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [LW-1:0] d_wdata_i;
   logic [BW-1:0] d_be_i;
   logic          d_gnt_o, d_rvalid_o;
   logic [LW-1:0] d_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_wdata_o;
   logic [BW-1:0] mem_be_o;
   logic          mem_gnt_i, mem_rvalid_i;
   logic [LW-1:0] mem_rdata_i;

   imem_port_arbiter #(.LINEWIDTH(LW), .ADDRW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_ready_o   (if_ready_o),
      .if_valid_o   (if_valid_o),
      .if_line_o    (if_line_o),
      .d_req_i      (d_req_i),
      .d_we_i       (d_we_i),
      .d_addr_i     (d_addr_i),
      .d_wdata_i    (d_wdata_i),
      .d_be_i       (d_be_i),
      .d_gnt_o      (d_gnt_o),
      .d_rvalid_o   (d_rvalid_o),
      .d_rdata_o    (d_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          own_d;
      logic [LW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (if_valid_o || d_rvalid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_response", {62'd0, if_valid_o, d_rvalid_o}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check1("resp_both_valid", if_valid_o & d_rvalid_o, 1'b0);
            check1("resp_owner_d", d_rvalid_o, mon_e.own_d);
            check("resp_data", d_rvalid_o ? d_rdata_o : if_line_o, mon_e.data);
         end
      end else begin
         check("quiet_if_line", if_line_o, 64'd0);
         check("quiet_d_rdata", d_rdata_o, 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic own_d, input logic [LW-1:0] data);
      exp_t e;
      e.own_d = own_d;
      e.data  = data;
      exp_q.push_back(e);
   endtask

   // Entered at the start of the REQ cycle: grant now, respond next cycle.
   task automatic serve(input logic [LW-1:0] data);
      mem_gnt_i = 1'b1;
      mid();
      check1("req_mem_req", mem_req_o, 1'b1);
      check("req_no_accept", {62'd0, if_ready_o, d_gnt_o}, 64'd0);
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      mid();
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   logic own_tbl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      rst = 1'b1; flush_i = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h104;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

      // Reset: nothing accepted, nothing requested.
      tick();
      mid();
      check1("rst_if_ready", if_ready_o, 1'b0);
      check1("rst_d_gnt", d_gnt_o, 1'b0);
      check1("rst_mem_req", mem_req_o, 1'b0);
      check1("rst_if_valid", if_valid_o, 1'b0);
      check1("rst_d_rvalid", d_rvalid_o, 1'b0);
      tick();
      rst = 1'b0; d_req_i = 1'b0;

      // Basic fetch at minimum latency.
      mid();
      check1("f1_if_ready", if_ready_o, 1'b1);
      check1("f1_d_gnt", d_gnt_o, 1'b0);
      tick();
      if_req_i = 1'b0;
      check("f1_mem_addr", 64'(mem_addr_o), 64'h100);
      check1("f1_mem_we", mem_we_o, 1'b0);
      check("f1_mem_be", 64'(mem_be_o), 64'hFF);
      push_exp(1'b0, 64'hDEADBEEF_CAFEF00D);
      serve(64'hDEADBEEF_CAFEF00D);

      // Round-robin with both requesters held high from a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h40F;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
      for (int i = 0; i < 4; i++) begin
         mid();
         check1("rr_if_ready", if_ready_o, ~own_tbl[i]);
         check1("rr_d_gnt", d_gnt_o, own_tbl[i]);
         tick();
         check("rr_mem_addr", 64'(mem_addr_o), own_tbl[i] ? 64'h300 : 64'h408);
         push_exp(own_tbl[i], 64'h1000 + 64'(i));
         serve(64'h1000 + 64'(i));
      end
      if_req_i = 1'b0; d_req_i = 1'b0;

      // Flush during RESP drops the late response.
      if_req_i = 1'b1; if_addr_i = 32'h1C8;
      mid();
      check1("fl_if_ready", if_ready_o, 1'b1);
      tick();
      if_req_i = 1'b0; mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      tick();
      tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111;
      mid();
      check1("fl_dropped_valid", if_valid_o, 1'b0);
      tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      // Request with flush in IDLE is accepted and returns normally.
      if_req_i = 1'b1; if_addr_i = 32'h200; flush_i = 1'b1;
      mid();
      check1("fl_new_if_ready", if_ready_o, 1'b1);
      tick();
      if_req_i = 1'b0; flush_i = 1'b0;
      check("fl_new_mem_addr", 64'(mem_addr_o), 64'h200);
      push_exp(1'b0, 64'h2222_3333_4444_5555);
      serve(64'h2222_3333_4444_5555);

      // Flush coincident with the fetch response.
      if_req_i = 1'b1; if_addr_i = 32'h50;
      tick();
      if_req_i = 1'b0; mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h3333;
      mid();
      check1("flr_if_valid", if_valid_o, 1'b0);
      tick();
      flush_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

      // Flush never affects a data read.
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80;
      mid();
      check1("dr_d_gnt", d_gnt_o, 1'b1);
      tick();
      d_req_i = 1'b0; flush_i = 1'b1;
      push_exp(1'b1, 64'h4444_0000_0000_4444);
      serve(64'h4444_0000_0000_4444);
      flush_i = 1'b0;

      // Data write held off by a slow grant: payload must stay stable.
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40;
      d_wdata_i = 64'h0123_4567_89AB_CDEF; d_be_i = 8'h0F;
      mid();
      check1("dw_d_gnt", d_gnt_o, 1'b1);
      tick();
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'hFFC; d_wdata_i = '0; d_be_i = 8'hF0;
      for (int k = 0; k < 5; k++) begin
         mid();
         check1("dw_mem_req", mem_req_o, 1'b1);
         check1("dw_mem_we", mem_we_o, 1'b1);
         check("dw_mem_addr", 64'(mem_addr_o), 64'h40);
         check("dw_mem_be", 64'(mem_be_o), 64'h0F);
         check("dw_mem_wdata", mem_wdata_o, 64'h0123_4567_89AB_CDEF);
         tick();
      end
      push_exp(1'b1, 64'd0);
      serve(64'd0);

      // Reset in RESP, then a stray response while the next fetch arrives.
      if_req_i = 1'b1; if_addr_i = 32'h600;
      tick();
      if_req_i = 1'b0; mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; rst = 1'b1;
      mid();
      check1("rr_rst_if_valid", if_valid_o, 1'b0);
      check1("rr_rst_mem_req", mem_req_o, 1'b0);
      tick();
      rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5555;
      if_req_i = 1'b1; if_addr_i = 32'h700;
      mid();
      check1("stray_if_valid", if_valid_o, 1'b0);
      check1("stray_d_rvalid", d_rvalid_o, 1'b0);
      check1("post_rst_if_ready", if_ready_o, 1'b1);
      tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = '0; if_req_i = 1'b0;
      check("post_rst_mem_addr", 64'(mem_addr_o), 64'h700);
      push_exp(1'b0, 64'h7777_8888_9999_AAAA);
      serve(64'h7777_8888_9999_AAAA);

      tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
